fifo_word_packer: RTL

//  Read-side consumer of the byte FIFO. Drains 8-bit entries via RREQ/e/RD and packs

---
 rtl/fifo_word_packer.sv | 101 ++++++++++
 1 files changed

// File: rtl/fifo_word_packer.sv
// Drains a byte FIFO and packs four bytes into a 32-bit valid/ready word.
// Optional partial-word flush on FIFO idle: define FIFO_RD_FLUSH_EN.
module fifo_word_packer #(
  parameter int BIG_END = 0,
  parameter int WCNT_W  = 16,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              e,
  output logic              RREQ,
  input  logic [7:0]        RD,
  output logic [31:0]       out_data,
  output logic [3:0]        out_be,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WCNT_W-1:0] word_cnt
);

  typedef enum logic {FILL, SEND} state_t;

  state_t     state;
  logic [2:0] req_cnt;
  logic [2:0] cap_cnt;
  logic       rd_pend;
  logic [1:0] lane;

  assign RREQ = (state == FILL) & ~e & (req_cnt < 3'd4);
  assign lane = (BIG_END != 0) ? (2'd3 - cap_cnt[1:0]) : cap_cnt[1:0];

`ifdef FIFO_RD_FLUSH_EN
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  logic [TW-1:0] tcnt;
  logic          flush_go;
  logic [3:0]    fl_be;
  logic [31:0]   fl_data;

  // tcnt holds the number of consecutive empty cycles before this one
  assign flush_go = (state == FILL) && e && (cap_cnt != 3'd0) && (cap_cnt < 3'd4) &&
                    (req_cnt == cap_cnt) && (tcnt == TW'(TIMEOUT - 1));
  assign fl_be    = 4'((4'd1 << cap_cnt) - 4'd1);
  // big-endian partials are shifted down so the valid bytes sit in the enabled lanes
  assign fl_data  = (BIG_END != 0) ? (out_data >> {3'd4 - cap_cnt, 3'b000})
                                   : (out_data & {{8{fl_be[3]}}, {8{fl_be[2]}},
                                                  {8{fl_be[1]}}, {8{fl_be[0]}}});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               tcnt <= '0;
    else if (!e || RREQ)    tcnt <= '0;
    else if (tcnt != TW'(TIMEOUT - 1)) tcnt <= tcnt + 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= FILL;
      req_cnt   <= '0;
      cap_cnt   <= '0;
      rd_pend   <= 1'b0;
      out_data  <= '0;
      out_be    <= '0;
      out_valid <= 1'b0;
      word_cnt  <= '0;
    end else begin
      rd_pend <= RREQ;
      case (state)
        FILL: begin
          if (RREQ) req_cnt <= req_cnt + 3'd1;
          if (rd_pend) begin
            out_data[lane*8 +: 8] <= RD;
            cap_cnt <= cap_cnt + 3'd1;
            if (cap_cnt == 3'd3) begin
              state     <= SEND;
              out_valid <= 1'b1;
              out_be    <= 4'hF;
            end
          end
`ifdef FIFO_RD_FLUSH_EN
          else if (flush_go) begin
            state     <= SEND;
            out_valid <= 1'b1;
            out_be    <= fl_be;
            out_data  <= fl_data;
          end
`endif
        end
        SEND: begin
          if (out_ready) begin
            state     <= FILL;
            out_valid <= 1'b0;
            req_cnt   <= '0;
            cap_cnt   <= '0;
            word_cnt  <= word_cnt + 1'b1;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule
